// File: rtl/amm_pkg.sv
// Shared types for the Avalon-MM memory responder: stall modes and the
// stall-generator LFSR definition.
package amm_pkg;

    typedef enum logic [1:0] {
        STALL_NONE     = 2'd0,
        STALL_EXT      = 2'd1,
        STALL_PERIODIC = 2'd2,
        STALL_RANDOM   = 2'd3
    } stall_mode_e;

    // Fibonacci taps 16,14,13,11 mapped onto bit indices 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] value);
        return {value[14:0], ^(value & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/amm_stall_gen.sv
// Programmable waitrequest source for one Avalon-MM port. The counter and the
// LFSR run every cycle so switching modes never restarts a pattern.
module amm_stall_gen
    import amm_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       srst_n,
    input  logic [1:0] mode,
    input  logic       stall_ext,
    output logic       waitrequest
);

    logic [1:0]  cnt_reg;
    logic [15:0] lfsr_reg;
    logic        wait_reg;
    logic        wait_next;
    stall_mode_e mode_sel;

    assign mode_sel = stall_mode_e'(mode);

    always_comb begin
        wait_next = 1'b0;
        case (mode_sel)
            STALL_NONE:     wait_next = 1'b0;
            STALL_EXT:      wait_next = stall_ext;
            STALL_PERIODIC: wait_next = ~cnt_reg[1];   // stall on counts 0 and 1
            STALL_RANDOM:   wait_next = lfsr_reg[0];
            default:        wait_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            cnt_reg  <= 2'd0;
            lfsr_reg <= LFSR_SEED;
            wait_reg <= 1'b1;
        end else begin
            cnt_reg  <= cnt_reg + 2'd1;
            lfsr_reg <= lfsr_step(lfsr_reg);
            wait_reg <= wait_next;
        end
    end

    assign waitrequest = wait_reg;

endmodule

// File: rtl/amm_mem_responder.sv
// Dual-master Avalon-MM memory: one read-only and one write-only port sharing
// a word array, fixed read latency, and programmable backpressure per port.
module amm_mem_responder
    import amm_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 10,
    parameter int          BYTE_CNT   = DATA_WIDTH / 8,
    parameter int          RD_LATENCY = 2,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic [1:0]            rd_stall_mode_i,
    input  logic [1:0]            wr_stall_mode_i,
    input  logic                  rd_stall_i,
    input  logic                  wr_stall_i,
    input  logic [ADDR_WIDTH-1:0] amm_rd_address_i,
    input  logic                  amm_rd_read_i,
    output logic [DATA_WIDTH-1:0] amm_rd_readdata_o,
    output logic                  amm_rd_readdatavalid_o,
    output logic                  amm_rd_waitrequest_o,
    input  logic [ADDR_WIDTH-1:0] amm_wr_address_i,
    input  logic                  amm_wr_write_i,
    input  logic [DATA_WIDTH-1:0] amm_wr_writedata_i,
    input  logic [BYTE_CNT-1:0]   amm_wr_byteenable_i,
    output logic                  amm_wr_waitrequest_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  rd_accept;
    logic                  wr_accept;
    logic                  valid_pipe_reg [RD_LATENCY];
    logic [DATA_WIDTH-1:0] data_pipe_reg  [RD_LATENCY];

    amm_stall_gen #(.LFSR_SEED(LFSR_SEED)) u_rd_stall (
        .clk         (clk_i),
        .srst_n      (srst_i),
        .mode        (rd_stall_mode_i),
        .stall_ext   (rd_stall_i),
        .waitrequest (amm_rd_waitrequest_o)
    );

    amm_stall_gen #(.LFSR_SEED(LFSR_SEED)) u_wr_stall (
        .clk         (clk_i),
        .srst_n      (srst_i),
        .mode        (wr_stall_mode_i),
        .stall_ext   (wr_stall_i),
        .waitrequest (amm_wr_waitrequest_o)
    );

    // Waitrequest may still be low in the reset cycle, so gate with reset too.
    assign rd_accept = srst_i && amm_rd_read_i  && !amm_rd_waitrequest_o;
    assign wr_accept = srst_i && amm_wr_write_i && !amm_wr_waitrequest_o;

    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            for (int b = 0; b < BYTE_CNT; b++) begin
                if (amm_wr_byteenable_i[b]) begin
                    mem[amm_wr_address_i][b*8 +: 8] <= amm_wr_writedata_i[b*8 +: 8];
                end
            end
        end
    end

    // Each stage only loads when its predecessor is valid, so the last stage
    // naturally holds readdata between responses.
    generate
        for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk_i) begin
                    if (!srst_i) begin
                        valid_pipe_reg[0] <= 1'b0;
                        data_pipe_reg[0]  <= '0;
                    end else begin
                        valid_pipe_reg[0] <= rd_accept;
                        if (rd_accept) begin
                            data_pipe_reg[0] <= mem[amm_rd_address_i];
                        end
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk_i) begin
                    if (!srst_i) begin
                        valid_pipe_reg[gi] <= 1'b0;
                        data_pipe_reg[gi]  <= '0;
                    end else begin
                        valid_pipe_reg[gi] <= valid_pipe_reg[gi-1];
                        if (valid_pipe_reg[gi-1]) begin
                            data_pipe_reg[gi] <= data_pipe_reg[gi-1];
                        end
                    end
                end
            end
        end
    endgenerate

    assign amm_rd_readdata_o      = data_pipe_reg[RD_LATENCY-1];
    assign amm_rd_readdatavalid_o = valid_pipe_reg[RD_LATENCY-1];

endmodule

// File: tb/tb_amm_mem_responder.sv
// Scoreboard bench for amm_mem_responder: a cycle-level reference model predicts
// waitrequest and read responses; a negedge monitor compares the DUT against it.
module tb_amm_mem_responder;

    localparam int          DW   = 32;
    localparam int          AW   = 10;
    localparam int          BC   = DW / 8;
    localparam int          LAT  = 2;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          TMO  = 64;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            due;
    } rd_exp_t;

    logic          clk_i_tb = 1'b0;
    logic          srst_i   = 1'b0;
    logic [1:0]    rd_mode  = 2'd0;
    logic [1:0]    wr_mode  = 2'd0;
    logic          rd_stall = 1'b0;
    logic          wr_stall = 1'b0;
    logic [AW-1:0] rd_addr  = '0;
    logic          rd_read  = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_wait;
    logic [AW-1:0] wr_addr  = '0;
    logic          wr_write = 1'b0;
    logic [DW-1:0] wr_data  = '0;
    logic [BC-1:0] wr_be    = '0;
    logic          wr_wait;

    int n_cmp = 0;
    int n_mis = 0;

    // reference model state
    int            cyc = 0;
    logic [DW-1:0] ref_mem [2**AW];
    rd_exp_t       rd_q[$];
    logic          mdl_rd_wait = 1'b1;
    logic          mdl_wr_wait = 1'b1;
    int            rd_cnt = 0, wr_cnt = 0;
    logic [15:0]   rd_lfsr = SEED, wr_lfsr = SEED;
    logic          rd_acc_flag = 1'b0, wr_acc_flag = 1'b0;
    logic [DW-1:0] exp_last = '0;
    logic          mon_en = 1'b0;
    logic          verbose = 1'b0;
    int            pulse_cnt = 0;
    logic          ext_run = 1'b0;

    amm_mem_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_CNT(BC),
        .RD_LATENCY(LAT), .LFSR_SEED(SEED)
    ) dut (
        .clk_i                  (clk_i_tb),
        .srst_i                 (srst_i),
        .rd_stall_mode_i        (rd_mode),
        .wr_stall_mode_i        (wr_mode),
        .rd_stall_i             (rd_stall),
        .wr_stall_i             (wr_stall),
        .amm_rd_address_i       (rd_addr),
        .amm_rd_read_i          (rd_read),
        .amm_rd_readdata_o      (rd_data),
        .amm_rd_readdatavalid_o (rd_valid),
        .amm_rd_waitrequest_o   (rd_wait),
        .amm_wr_address_i       (wr_addr),
        .amm_wr_write_i         (wr_write),
        .amm_wr_writedata_i     (wr_data),
        .amm_wr_byteenable_i    (wr_be),
        .amm_wr_waitrequest_o   (wr_wait)
    );

    always #5 clk_i_tb = ~clk_i_tb;

    function automatic logic [15:0] ref_lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic ref_stall(input logic [1:0] mode, input logic ext,
                                       input int cnt, input logic [15:0] lfsr);
        case (mode)
            2'd0:    return 1'b0;
            2'd1:    return ext;
            2'd2:    return (cnt % 4) < 2;
            default: return lfsr[0];
        endcase
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: evaluates the acceptance rules at each rising edge.
    always @(posedge clk_i_tb) begin
        cyc++;
        rd_acc_flag = 1'b0;
        wr_acc_flag = 1'b0;
        if (!srst_i) begin
            rd_q.delete();
            exp_last    = '0;
            mdl_rd_wait = 1'b1;
            mdl_wr_wait = 1'b1;
            rd_cnt = 0;  wr_cnt = 0;
            rd_lfsr = SEED; wr_lfsr = SEED;
        end else begin
            if (rd_read && !mdl_rd_wait) begin
                rd_q.push_back('{addr: rd_addr, data: ref_mem[rd_addr], due: cyc + LAT - 1});
                rd_acc_flag = 1'b1;
            end
            if (wr_write && !mdl_wr_wait) begin
                for (int b = 0; b < BC; b++)
                    if (wr_be[b]) ref_mem[wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
                wr_acc_flag = 1'b1;
                if (verbose)
                    $display("wr  addr=%03h data=%h be=%b cycle=%0d", wr_addr, wr_data, wr_be, cyc);
            end
            mdl_rd_wait = ref_stall(rd_mode, rd_stall, rd_cnt, rd_lfsr);
            mdl_wr_wait = ref_stall(wr_mode, wr_stall, wr_cnt, wr_lfsr);
            rd_cnt++;  wr_cnt++;
            rd_lfsr = ref_lfsr_next(rd_lfsr);
            wr_lfsr = ref_lfsr_next(wr_lfsr);
        end
    end

    // Monitor: compares DUT outputs with the model on every falling edge.
    always @(negedge clk_i_tb) begin
        if (mon_en) begin
            logic    exp_v;
            rd_exp_t e;
            chk("rd_waitrequest", {31'd0, rd_wait}, {31'd0, mdl_rd_wait});
            chk("wr_waitrequest", {31'd0, wr_wait}, {31'd0, mdl_wr_wait});
            exp_v = (rd_q.size() > 0) && (rd_q[0].due == cyc);
            chk("readdatavalid", {31'd0, rd_valid}, {31'd0, exp_v});
            if (rd_valid) pulse_cnt++;
            if (exp_v) begin
                e = rd_q.pop_front();
                if (rd_valid) begin
                    chk("readdata", rd_data, e.data);
                    $display("rd  addr=%03h data=%h want=%h cycle=%0d", e.addr, rd_data, e.data, cyc);
                end
                exp_last = e.data;
            end else if (!rd_valid) begin
                chk("readdata_hold", rd_data, exp_last);
            end
        end
    end

    task automatic do_rd(input logic [AW-1:0] a);
        int n;
        @(negedge clk_i_tb);
        rd_addr = a;
        rd_read = 1'b1;
        n = 0;
        do begin
            @(posedge clk_i_tb); #1; n++;
        end while (!rd_acc_flag && n < TMO);
        n_cmp++;
        if (!rd_acc_flag) begin
            n_mis++;
            $display("FAIL rd_accept_timeout: addr %h not accepted within %0d cycles", a, TMO);
        end
        rd_read = 1'b0;
    endtask

    task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BC-1:0] be);
        int n;
        @(negedge clk_i_tb);
        wr_addr  = a;
        wr_data  = d;
        wr_be    = be;
        wr_write = 1'b1;
        n = 0;
        do begin
            @(posedge clk_i_tb); #1; n++;
        end while (!wr_acc_flag && n < TMO);
        n_cmp++;
        if (!wr_acc_flag) begin
            n_mis++;
            $display("FAIL wr_accept_timeout: addr %h not accepted within %0d cycles", a, TMO);
        end
        wr_write = 1'b0;
    endtask

    task automatic set_modes(input logic [1:0] rm, input logic [1:0] wm);
        @(negedge clk_i_tb);
        rd_mode = rm;
        wr_mode = wm;
        repeat (LAT + 2) @(posedge clk_i_tb);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk_i_tb);
        mon_en = 1'b1;
        repeat (3) @(posedge clk_i_tb);
        @(negedge clk_i_tb);
        srst_i = 1'b1;

        // fill the array so every later read has defined contents
        for (int a = 0; a < 2**AW; a++) do_wr(AW'(a), $urandom, 4'hF);
        verbose = 1'b1;

        // directed, mode 0
        do_wr(10'h010, 32'h11223344, 4'hF);
        do_rd(10'h010);
        do_wr(10'h010, 32'hAABBCCDD, 4'b0101);
        do_rd(10'h010);
        do_wr(10'h010, 32'h00000000, 4'b0000);
        do_rd(10'h010);
        do_wr(10'h020, 32'h00000000, 4'hF);
        fork
            do_rd(10'h020);
            do_wr(10'h020, 32'hFFFFFFFF, 4'hF);
        join
        do_rd(10'h020);
        for (int i = 0; i < 16; i++) do_rd(AW'(i));
        repeat (LAT + 2) @(posedge clk_i_tb);

        // mode 2: periodic stall on both ports
        set_modes(2'd2, 2'd2);
        for (int i = 0; i < 16; i++) do_wr(AW'(i), $urandom, 4'hF);
        pulse_cnt = 0;
        for (int i = 0; i < 16; i++) do_rd(AW'(i));
        repeat (LAT + 2) @(posedge clk_i_tb);
        chk("mode2_pulse_count", pulse_cnt, 16);

        // mode 1: externally driven stall
        set_modes(2'd1, 2'd1);
        ext_run = 1'b1;
        fork
            while (ext_run) begin
                @(negedge clk_i_tb);
                rd_stall = 1'($urandom);
                wr_stall = 1'($urandom);
            end
            begin
                fork
                    for (int i = 0; i < 20; i++) do_rd(AW'($urandom_range(0, 31)));
                    for (int i = 0; i < 20; i++) do_wr(AW'($urandom_range(0, 31)), $urandom, BC'($urandom));
                join
                ext_run = 1'b0;
            end
        join
        rd_stall = 1'b0;
        wr_stall = 1'b0;

        // mode 3: pseudo-random stall, 200 random transactions
        set_modes(2'd3, 2'd3);
        fork
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(0, 3) == 0) @(posedge clk_i_tb);
                do_rd(AW'($urandom_range(0, 31)));
            end
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(0, 3) == 0) @(posedge clk_i_tb);
                do_wr(AW'($urandom_range(0, 31)), $urandom, BC'($urandom));
            end
        join
        repeat (LAT + 2) @(posedge clk_i_tb);

        // reset one cycle after a read is accepted; a write during reset is dropped
        set_modes(2'd0, 2'd0);
        pulse_cnt = 0;
        do_rd(10'h005);
        @(negedge clk_i_tb);
        srst_i   = 1'b0;
        wr_addr  = 10'h005;
        wr_data  = 32'hDEADBEEF;
        wr_be    = 4'hF;
        wr_write = 1'b1;
        repeat (3) @(negedge clk_i_tb);
        wr_write = 1'b0;
        chk("reset_no_response", pulse_cnt, 0);
        srst_i = 1'b1;
        do_rd(10'h005);
        repeat (LAT + 2) @(posedge clk_i_tb);
        chk("reset_readback_count", pulse_cnt, 1);

        chk("queue_drained", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
